// File: rtl/aes128.sv
// Single-block AES-128 encrypt/decrypt: fully unrolled combinational rounds, registered output.
// Define AES128_DECRYPT_EN to build the inverse cipher; otherwise selCypher is ignored.
module aes128 (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] message_in,
    input  logic [127:0] key,
    input  logic         selCypher,
    output logic [127:0] message_out
);

    // State byte [r][c] lives at bits [127-8*(4r+c) -: 8] throughout.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*r+c) -: 8] = s[127-8*(4*r+src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        o = '0;
        k[0] = inv ? 8'h0e : 8'h02;
        k[1] = inv ? 8'h0b : 8'h03;
        k[2] = inv ? 8'h0d : 8'h01;
        k[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*r+c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(4*r+c) -: 8] = gf_mul(a[r], k[0]) ^ gf_mul(a[(r+1)%4], k[1])
                                      ^ gf_mul(a[(r+2)%4], k[2]) ^ gf_mul(a[(r+3)%4], k[3]);
        end
        return o;
    endfunction

    // Column 0 takes SubWord(RotWord(col3)) ^ Rcon; each later column chains off its new left neighbour.
    function automatic logic [127:0] next_rk(input logic [127:0] rk, input logic [7:0] rcon);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            o[127-8*(4*r) -: 8] = rk[127-8*(4*r) -: 8] ^ sbox(rk[127-8*(4*((r+1)%4)+3) -: 8])
                                ^ ((r == 0) ? rcon : 8'h00);
        for (int c = 1; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*r+c) -: 8] = rk[127-8*(4*r+c) -: 8] ^ o[127-8*(4*r+c-1) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] msg, input logic [127:0] k);
        logic [127:0] st;
        logic [127:0] rk;
        logic [7:0]   rcon;
        rk   = k;
        rcon = 8'h01;
        st   = msg ^ rk;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            rk   = next_rk(rk, rcon);
            rcon = xtime(rcon);
            st   = shift_rows(sub_bytes(st, 1'b0), 1'b0);
            if (rnd != 10) st = mix_columns(st, 1'b0);
            st = st ^ rk;
        end
        return st;
    endfunction

    function automatic logic [127:0] aes_decrypt(input logic [127:0] msg, input logic [127:0] k);
        logic [127:0] st;
        logic [127:0] rks [11];
        logic [7:0]   rcon;
        rks[0] = k;
        rcon   = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rks[i] = next_rk(rks[i-1], rcon);
            rcon   = xtime(rcon);
        end
        st = msg ^ rks[10];
        for (int rnd = 9; rnd >= 1; rnd--) begin
            st = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rks[rnd];
            st = mix_columns(st, 1'b1);
        end
        return sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rks[0];
    endfunction

    logic [127:0] w_result;
    logic [127:0] r_out;

`ifdef AES128_DECRYPT_EN
    assign w_result = selCypher ? aes_decrypt(message_in, key) : aes_encrypt(message_in, key);
`else
    logic w_unused_sel;
    assign w_unused_sel = selCypher;
    assign w_result     = aes_encrypt(message_in, key);
`endif

    // NOTE: async clear in the sensitivity list, and <= so the flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_out <= '0;
        else        r_out <= w_result;
    end

    assign message_out = r_out;

endmodule

// File: tb/tb_aes128.sv
// Scoreboard bench for aes128: FIPS-197 vectors, back-to-back streaming, async reset and random traffic
// checked against a byte-array AES reference model built from log/antilog tables.
module tb_aes128;

    localparam logic [127:0] PT_B  = 128'h328831E0435A3137F6309807A88DA234;
    localparam logic [127:0] KEY_B = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
    localparam logic [127:0] CT_B  = 128'h3902DC1925DC116A8409850B1DFB9732;
    localparam logic [127:0] PT_C  = 128'h004488CC115599DD2266AAEE3377BBFF;
    localparam logic [127:0] KEY_C = 128'h0004080C0105090D02060A0E03070B0F;
    localparam logic [127:0] CT_C  = 128'h696AD870C47BCDB4E004B7C5D830805A;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] message_in;
    logic [127:0] key;
    logic         sel_cypher;
    logic [127:0] message_out;

    typedef struct {
        logic [127:0] exp;
        int           id;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_err  = 0;
    int         vec_id = 0;
    logic [7:0] sbox_tab [256];

    aes128 dut (
        .clk        (clk),
        .reset      (reset),
        .message_in (message_in),
        .key        (key),
        .selCypher  (sel_cypher),
        .message_out(message_out)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from powers of the generator 0x03: inverse via logs, then the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] v;
        logic [7:0] inv;
        logic [7:0] cst;
        logic [7:0] s;
        v   = 8'h01;
        cst = 8'h63;
        for (int i = 0; i < 256; i++) lg[i] = 0;
        for (int i = 0; i < 255; i++) begin
            ex[i] = v;
            lg[v] = i;
            v     = v ^ xt(v);
        end
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sbox_tab[a] = s;
        end
    endtask

    // Reference cipher in FIPS byte order (n = r + 4c) with a 44-word key schedule.
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   kb [16];
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) begin
            st[n] = pt[127-8*(4*(n%4) + n/4) -: 8];
            kb[n] = k[127-8*(4*(n%4) + n/4) -: 8];
        end
        for (int i = 0; i < 4; i++) w[i] = {kb[4*i], kb[4*i+1], kb[4*i+2], kb[4*i+3]};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t  = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int n = 0; n < 16; n++) tmp[n] = sbox_tab[st[n]];
            for (int n = 0; n < 16; n++) st[n] = tmp[(n%4) + 4*(((n/4) + (n%4)) % 4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) st[n] = st[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
        end
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*(4*(n%4) + n/4) -: 8] = st[n];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(input logic [127:0] m, input logic [127:0] k, input logic s,
                         input logic [127:0] e);
        @(negedge clk);
        message_in = m;
        key        = k;
        sel_cypher = s;
        exp_q.push_back('{e, vec_id});
        vec_id++;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every edge taken out of reset with a pending expectation is one result to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset && exp_q.size() != 0) begin
                #1;
                e = exp_q.pop_front();
                check($sformatf("vec%0d", e.id), message_out, e.exp);
            end
        end
    end

    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        logic         rs;
        build_sbox();
        reset      = 1'b0;
        message_in = '0;
        key        = '0;
        sel_cypher = 1'b0;
        #1 check("reset_state", message_out, 128'h0);
        #4 reset = 1'b1;

        apply(PT_B, KEY_B, 1'b0, CT_B);
        apply(PT_C, KEY_C, 1'b0, CT_C);
`ifdef AES128_DECRYPT_EN
        apply(CT_B, KEY_B, 1'b1, PT_B);
        apply(CT_C, KEY_C, 1'b1, PT_C);
`else
        apply(PT_B, KEY_B, 1'b1, CT_B);
        apply(PT_C, KEY_C, 1'b1, CT_C);
`endif
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) apply(PT_B, KEY_B, 1'b0, CT_B);
            else            apply(PT_C, KEY_C, 1'b0, CT_C);
        end
        drain();

        // Reset between edges with a nonzero output and a new input pending.
        apply(PT_B, KEY_B, 1'b0, CT_B);
        drain();
        @(negedge clk);
        message_in = PT_C;
        key        = KEY_C;
        #2 reset = 1'b0;
        #1 check("reset_async", message_out, 128'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 check("reset_hold", message_out, 128'h0);
        end
        @(posedge clk);
        #5 reset = 1'b1;
        apply(PT_B, KEY_B, 1'b0, CT_B);
        drain();

        for (int i = 0; i < 300; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            rs = 1'($urandom_range(0, 1));
`ifdef AES128_DECRYPT_EN
            if (rs) apply(ref_encrypt(rp, rk), rk, 1'b1, rp);
            else    apply(rp, rk, 1'b0, ref_encrypt(rp, rk));
`else
            apply(rp, rk, rs, ref_encrypt(rp, rk));
`endif
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
